// File: rtl/isp8_flow_pkg.sv
// isp8_flow_pkg: shared encodings for the ISP8 flow controller.
// Holds jump-condition codes, the bus phase enum and a priority helper.
package isp8_flow_pkg;

    localparam logic [2:0] JC_ALWAYS = 3'd0;
    localparam logic [2:0] JC_Z      = 3'd1;
    localparam logic [2:0] JC_NZ     = 3'd2;
    localparam logic [2:0] JC_C      = 3'd3;
    localparam logic [2:0] JC_NC     = 3'd4;

    typedef enum logic [1:0] {
        PH_ADDR = 2'd0,
        PH_EXT  = 2'd1,
        PH_DATA = 2'd2
    } phase_e;

    // Index of the lowest set bit; bit 0 is the highest priority.
    function automatic logic [2:0] lsb_idx(input logic [7:0] v);
        lsb_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) lsb_idx = 3'(i);
        end
    endfunction

endpackage

// File: rtl/isp8_intr_flow_cntl_if.sv
// isp8_intr_flow_cntl_if: opcode, ALU, irq and fetch signals of the
// ISP8 flow controller; master drives opcodes, slave is the controller.
interface isp8_intr_flow_cntl_if #(
    parameter int PROM_AW = 12,
    parameter int NUM_IRQ = 4
);
    logic               setc, clrc, setz, clrz, seti, clri;
    logic               jmp_valid, jmp_call;
    logic [2:0]         jmp_cond;
    logic [PROM_AW-1:0] jmp_offset;
    logic               ret, iret;
    logic               ext_cycle, ready;
    logic               update_c, update_z, cout_alu;
    logic [7:0]         dout_alu;
    logic [NUM_IRQ-1:0] irq;
    logic               addr_cyc, ext_addr_cyc, data_cyc;
    logic [PROM_AW-1:0] prom_addr;
    logic               prom_enable;
    logic               carry_flag, zero_flag;
    logic [NUM_IRQ-1:0] intr_ack;
    logic               stack_ovf, stack_unf;

    modport master (
        output setc, clrc, setz, clrz, seti, clri,
        output jmp_valid, jmp_call, jmp_cond, jmp_offset,
        output ret, iret, ext_cycle, ready,
        output update_c, update_z, cout_alu, dout_alu, irq,
        input  addr_cyc, ext_addr_cyc, data_cyc,
        input  prom_addr, prom_enable, carry_flag, zero_flag,
        input  intr_ack, stack_ovf, stack_unf
    );

    modport slave (
        input  setc, clrc, setz, clrz, seti, clri,
        input  jmp_valid, jmp_call, jmp_cond, jmp_offset,
        input  ret, iret, ext_cycle, ready,
        input  update_c, update_z, cout_alu, dout_alu, irq,
        output addr_cyc, ext_addr_cyc, data_cyc,
        output prom_addr, prom_enable, carry_flag, zero_flag,
        output intr_ack, stack_ovf, stack_unf
    );

endinterface

// File: rtl/isp8_pgm_stack.sv
// isp8_pgm_stack: return-address stack with sticky overflow/underflow.
// Push when full is dropped; pop when empty reads back zero.
module isp8_pgm_stack #(
    parameter int AW = 4,
    parameter int DW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          ovf,
    output logic          unf
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          full, empty;
    logic [AW-1:0] top_idx;

    assign full    = cnt_q[AW];
    assign empty   = (cnt_q == '0);
    assign top_idx = AW'(cnt_q - 1'b1);
    assign rdata   = empty ? '0 : mem_q[top_idx];
    assign ovf     = ovf_q;
    assign unf     = unf_q;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (push) begin
            if (full) ovf_d = 1'b1;
            else      cnt_d = cnt_q + 1'b1;
        end else if (pop) begin
            if (empty) unf_d = 1'b1;
            else       cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem_q[cnt_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/isp8_intr_flow_cntl.sv
// isp8_intr_flow_cntl: ISP8 bus phasing, PC sequencing, flags and irqs.
// Define ISP8_NESTED_INTR_EN to let higher-priority irqs preempt an ISR.
module isp8_intr_flow_cntl
    import isp8_flow_pkg::*;
#(
    parameter int PROM_AW      = 12,
    parameter int PGM_STACK_AW = 4,
    parameter int NUM_IRQ      = 4,
    parameter int VEC_STRIDE   = 4
) (
    input logic                  clk,
    input logic                  rst,
    isp8_intr_flow_cntl_if.slave bus
);
    localparam int SW = PROM_AW + 2;

    phase_e             state_q, state_d;
    logic               addr_cyc_q, ext_cyc_q, data_cyc_q;
    logic [PROM_AW-1:0] pc_q, pc_d, joff_q, joff_d;
    logic [PROM_AW-1:0] nxt_addr, vec_addr;
    logic               c_q, c_d, z_q, z_d, ie_q, ie_d;
    logic               jt_q, jt_d, jcall_q, jcall_d;
    logic               pend_q, pend_d;
    logic [2:0]         pidx_q, pidx_d;
    logic [7:0]         dout_q;
    logic [NUM_IRQ-1:0] ack_q, ack_d, elig;
    logic [7:0]         req8;
    logic               cond_ok, any_ret, rt, take_irq, push;
    logic [SW-1:0]      stk_top, stk_wdata;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PH_ADDR: state_d = bus.ext_cycle ? PH_EXT : PH_DATA;
            PH_EXT:  state_d = bus.ready ? PH_DATA : PH_EXT;
            PH_DATA: state_d = PH_ADDR;
            default: state_d = PH_ADDR;
        endcase
    end

    always_comb begin
        cond_ok = 1'b0;
        case (bus.jmp_cond)
            JC_ALWAYS: cond_ok = 1'b1;
            JC_Z:      cond_ok = z_q;
            JC_NZ:     cond_ok = ~z_q;
            JC_C:      cond_ok = c_q;
            JC_NC:     cond_ok = ~c_q;
            default:   cond_ok = 1'b0;
        endcase
    end

`ifdef ISP8_NESTED_INTR_EN
    logic [2:0] ack_lsb;
    assign ack_lsb = lsb_idx(8'(ack_q));
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            elig[i] = (ack_q == '0) || (3'(i) < ack_lsb);
        end
    end
`else
    assign elig = {NUM_IRQ{ack_q == '0}};
`endif

    assign req8 = 8'(bus.irq & elig);

    // Jump decision and irq request are frozen at ADDR for use in DATA.
    always_comb begin
        jt_d    = jt_q;
        jcall_d = jcall_q;
        joff_d  = joff_q;
        pend_d  = pend_q;
        pidx_d  = pidx_q;
        if (addr_cyc_q) begin
            jt_d    = bus.jmp_valid & cond_ok;
            jcall_d = bus.jmp_call;
            joff_d  = bus.jmp_offset;
            pend_d  = ie_q & (|req8);
            pidx_d  = lsb_idx(req8);
        end
    end

    assign any_ret  = bus.ret | bus.iret;
    assign rt       = data_cyc_q & any_ret;
    assign take_irq = data_cyc_q & pend_q & ~jt_q & ~any_ret;
    assign push     = take_irq | (data_cyc_q & jt_q & jcall_q & ~any_ret);
    assign vec_addr = PROM_AW'(32'(pidx_q) * 32'(VEC_STRIDE));

    always_comb begin
        nxt_addr = pc_q + 1'b1;
        priority case (1'b1)
            take_irq: nxt_addr = vec_addr;
            rt:       nxt_addr = stk_top[PROM_AW-1:0];
            jt_q:     nxt_addr = pc_q + joff_q;
            default:  nxt_addr = pc_q + 1'b1;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        c_d   = c_q;
        z_d   = z_q;
        ie_d  = ie_q;
        ack_d = ack_q;
        if (data_cyc_q) begin
            pc_d = nxt_addr;
            if (bus.clrc)          c_d = 1'b0;
            else if (bus.setc)     c_d = 1'b1;
            else if (bus.iret)     c_d = stk_top[SW-1];
            else if (bus.update_c) c_d = bus.cout_alu;
            if (bus.clrz)          z_d = 1'b0;
            else if (bus.setz)     z_d = 1'b1;
            else if (bus.iret)     z_d = stk_top[SW-2];
            else if (bus.update_z) z_d = (dout_q == 8'd0);
            if (bus.clri)          ie_d = 1'b0;
            else if (bus.seti)     ie_d = 1'b1;
            if (take_irq)          ack_d = ack_q | (NUM_IRQ'(1) << pidx_q);
            else if (bus.iret)     ack_d = ack_q & (ack_q - 1'b1);
        end
    end

    assign stk_wdata = {c_d, z_d, pc_q + 1'b1};

    isp8_pgm_stack #(
        .AW (PGM_STACK_AW),
        .DW (SW)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rt),
        .wdata (stk_wdata),
        .rdata (stk_top),
        .ovf   (bus.stack_ovf),
        .unf   (bus.stack_unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PH_ADDR;
            addr_cyc_q <= 1'b1;
            ext_cyc_q  <= 1'b0;
            data_cyc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_cyc_q <= (state_d == PH_ADDR);
            ext_cyc_q  <= (state_d == PH_EXT);
            data_cyc_q <= (state_d == PH_DATA);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            ie_q    <= 1'b0;
            ack_q   <= '0;
            jt_q    <= 1'b0;
            jcall_q <= 1'b0;
            joff_q  <= '0;
            pend_q  <= 1'b0;
            pidx_q  <= '0;
            dout_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            c_q     <= c_d;
            z_q     <= z_d;
            ie_q    <= ie_d;
            ack_q   <= ack_d;
            jt_q    <= jt_d;
            jcall_q <= jcall_d;
            joff_q  <= joff_d;
            pend_q  <= pend_d;
            pidx_q  <= pidx_d;
            dout_q  <= bus.dout_alu;
        end
    end

    assign bus.addr_cyc     = addr_cyc_q;
    assign bus.ext_addr_cyc = ext_cyc_q;
    assign bus.data_cyc     = data_cyc_q;
    assign bus.prom_addr    = rst ? '0 : (data_cyc_q ? nxt_addr : pc_q);
    assign bus.prom_enable  = data_cyc_q | rst;
    assign bus.carry_flag   = c_q;
    assign bus.zero_flag    = z_q;
    assign bus.intr_ack     = ack_q;

endmodule

// File: tb/tb_isp8_intr_flow_cntl.sv
// tb_isp8_intr_flow_cntl: instruction-level model of the flow controller
// compared every cycle, plus directed literal checks and random traffic.
module tb_isp8_intr_flow_cntl;
    localparam int AW    = 12;
    localparam int SAW   = 4;
    localparam int NI    = 4;
    localparam int VS    = 4;
    localparam int DEPTH = 2 ** SAW;
    localparam int MASK  = (1 << AW) - 1;

    typedef struct {
        bit c;
        bit z;
        int pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    isp8_intr_flow_cntl_if #(.PROM_AW(AW), .NUM_IRQ(NI)) bus ();

    isp8_intr_flow_cntl #(
        .PROM_AW      (AW),
        .PGM_STACK_AW (SAW),
        .NUM_IRQ      (NI),
        .VEC_STRIDE   (VS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int      m_pc;
    bit      m_c, m_z, m_ie, m_ovf, m_unf;
    bit [NI-1:0] m_ack;
    ent_t    stk[$];

    int exp_ph, exp_pa;
    bit chk_en = 1'b0;
    int n_cmp = 0, n_err = 0;
    int ext_seen = 0;
    int last_data_pa = -1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input bit [NI-1:0] v);
        for (int i = 0; i < NI; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("addr_cyc", bus.addr_cyc, exp_ph == 0);
            check("ext_addr_cyc", bus.ext_addr_cyc, exp_ph == 1);
            check("data_cyc", bus.data_cyc, exp_ph == 2);
            check("prom_enable", bus.prom_enable, exp_ph == 2);
            check("prom_addr", bus.prom_addr, exp_pa);
            check("carry", bus.carry_flag, m_c);
            check("zero", bus.zero_flag, m_z);
            check("intr_ack", bus.intr_ack, m_ack);
            check("stack_ovf", bus.stack_ovf, m_ovf);
            check("stack_unf", bus.stack_unf, m_unf);
        end
        if (bus.ext_addr_cyc === 1'b1) ext_seen++;
        if (bus.data_cyc === 1'b1) last_data_pa = int'(bus.prom_addr);
    end

    task automatic clr_ops();
        bus.setc = 0; bus.clrc = 0; bus.setz = 0; bus.clrz = 0;
        bus.seti = 0; bus.clri = 0;
        bus.jmp_valid = 0; bus.jmp_call = 0; bus.jmp_cond = 3'd0;
        bus.jmp_offset = '0;
        bus.ret = 0; bus.iret = 0;
        bus.ext_cycle = 0; bus.ready = 0;
        bus.update_c = 0; bus.update_z = 0; bus.cout_alu = 0;
        bus.dout_alu = 8'h00;
        bus.irq = '0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        clr_ops();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr_cyc", bus.addr_cyc, 1);
        check("rst_ext_cyc", bus.ext_addr_cyc, 0);
        check("rst_data_cyc", bus.data_cyc, 0);
        check("rst_prom_addr", bus.prom_addr, 0);
        check("rst_prom_en", bus.prom_enable, 1);
        check("rst_flags", {bus.carry_flag, bus.zero_flag}, 0);
        check("rst_ack", bus.intr_ack, 0);
        check("rst_ovf_unf", {bus.stack_ovf, bus.stack_unf}, 0);
        rst = 1'b0;
        m_pc = 0; m_c = 0; m_z = 0; m_ie = 0; m_ack = '0;
        m_ovf = 0; m_unf = 0;
        stk.delete();
        exp_ph = 0; exp_pa = 0;
        chk_en = 1'b1;
    endtask

    // One instruction: ADDR, optional EXT (nwait+1 cycles), DATA.
    task automatic run_instr(input int nwait);
        bit cok, taken, rt, take, push, nc, nz, nie, nov, nun;
        bit [NI-1:0] elig, req, nack;
        int idx, nxt;
        ent_t e;
        case (bus.jmp_cond)
            3'd0:    cok = 1;
            3'd1:    cok = m_z;
            3'd2:    cok = !m_z;
            3'd3:    cok = m_c;
            3'd4:    cok = !m_c;
            default: cok = 0;
        endcase
        taken = bus.jmp_valid && cok;
        for (int i = 0; i < NI; i++) begin
`ifdef ISP8_NESTED_INTR_EN
            elig[i] = (m_ack == 0) || (i < lowest(m_ack));
`else
            elig[i] = (m_ack == 0);
`endif
        end
        req  = bus.irq & elig;
        idx  = lowest(req);
        rt   = bus.ret || bus.iret;
        take = m_ie && (req != 0) && !taken && !rt;
        nov  = m_ovf;
        nun  = m_unf;
        e    = '{0, 0, 0};
        if (rt) begin
            if (stk.size() > 0) e = stk.pop_back();
            else nun = 1;
        end
        nc = bus.clrc ? 0 : bus.setc ? 1 : bus.iret ? e.c :
             bus.update_c ? bus.cout_alu : m_c;
        nz = bus.clrz ? 0 : bus.setz ? 1 : bus.iret ? e.z :
             bus.update_z ? (bus.dout_alu == 0) : m_z;
        nie = bus.clri ? 0 : bus.seti ? 1 : m_ie;
        push = take || (taken && bus.jmp_call && !rt);
        if (push) begin
            if (stk.size() < DEPTH) stk.push_back('{nc, nz, (m_pc + 1) & MASK});
            else nov = 1;
        end
        nack = m_ack;
        if (take) nack[idx] = 1;
        else if (bus.iret && m_ack != 0) nack[lowest(m_ack)] = 0;
        if (take)       nxt = (idx * VS) & MASK;
        else if (rt)    nxt = e.pc;
        else if (taken) nxt = (m_pc + int'(bus.jmp_offset)) & MASK;
        else            nxt = (m_pc + 1) & MASK;

        exp_ph = 0; exp_pa = m_pc;
        @(posedge clk); #1;
        if (bus.ext_cycle) begin
            for (int k = 0; k <= nwait; k++) begin
                exp_ph = 1;
                bus.ready = (k == nwait);
                @(posedge clk); #1;
            end
        end
        bus.ready = 0;
        exp_ph = 2; exp_pa = nxt;
        @(posedge clk); #1;
        m_pc = nxt; m_c = nc; m_z = nz; m_ie = nie; m_ack = nack;
        m_ovf = nov; m_unf = nun;
        exp_ph = 0; exp_pa = m_pc;
    endtask

    task automatic rand_ops(output int nwait);
        clr_ops();
        bus.setc = ($urandom_range(0, 15) == 0);
        bus.clrc = ($urandom_range(0, 15) == 0);
        bus.setz = ($urandom_range(0, 15) == 0);
        bus.clrz = ($urandom_range(0, 15) == 0);
        bus.seti = ($urandom_range(0, 3) == 0);
        bus.clri = ($urandom_range(0, 7) == 0);
        bus.jmp_valid = ($urandom_range(0, 3) == 0);
        bus.jmp_call = ($urandom_range(0, 1) == 0);
        bus.jmp_cond = 3'($urandom_range(0, 7));
        bus.jmp_offset = AW'($urandom);
        bus.ret = ($urandom_range(0, 11) == 0);
        bus.iret = !bus.ret && ($urandom_range(0, 7) == 0);
        bus.ext_cycle = ($urandom_range(0, 3) == 0);
        nwait = $urandom_range(0, 3);
        bus.update_c = ($urandom_range(0, 1) == 0);
        bus.update_z = ($urandom_range(0, 1) == 0);
        bus.cout_alu = ($urandom_range(0, 1) == 0);
        bus.dout_alu = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        bus.irq = ($urandom_range(0, 2) == 0) ? NI'($urandom) : '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, nw;
        clr_ops();
        do_reset();

        for (int i = 1; i <= 3; i++) begin
            clr_ops();
            run_instr(0);
            check("seq_pa", last_data_pa, i);
        end

        clr_ops();
        bus.ext_cycle = 1;
        e0 = ext_seen;
        run_instr(3);
        check("ext_len", ext_seen - e0, 4);
        check("ext_pa", last_data_pa, 4);

        clr_ops();
        bus.jmp_valid = 1; bus.jmp_offset = 12'h00C;
        run_instr(0);
        check("jmp_pa", last_data_pa, 12'h010);
        clr_ops();
        bus.jmp_valid = 1; bus.jmp_call = 1; bus.jmp_offset = 12'h020;
        run_instr(0);
        check("call_pa", last_data_pa, 12'h030);
        clr_ops();
        bus.ret = 1;
        run_instr(0);
        check("ret_pa", last_data_pa, 12'h011);

        clr_ops();
        bus.setc = 1; bus.seti = 1;
        run_instr(0);
        check("setc", bus.carry_flag, 1);
        clr_ops();
        bus.irq = 4'b0110;
        run_instr(0);
        check("irq_vec", last_data_pa, 12'h004);
        check("irq_ack", bus.intr_ack, 4'b0010);
        clr_ops();
        bus.clrc = 1;
        run_instr(0);
        check("isr_clrc", bus.carry_flag, 0);
        clr_ops();
        bus.iret = 1;
        run_instr(0);
        check("iret_pa", last_data_pa, 12'h013);
        check("iret_c", bus.carry_flag, 1);
        check("iret_ack", bus.intr_ack, 0);

        clr_ops();
        bus.irq = 4'b0100;
        run_instr(0);
        check("isr2_pa", last_data_pa, 12'h008);
        clr_ops();
        bus.irq = 4'b0001;
        run_instr(0);
`ifdef ISP8_NESTED_INTR_EN
        check("nest_pa", last_data_pa, 12'h000);
        check("nest_ack", bus.intr_ack, 4'b0101);
`else
        check("nest_pa", last_data_pa, 12'h009);
        check("nest_ack", bus.intr_ack, 4'b0100);
`endif

        clr_ops();
        bus.ext_cycle = 1;
        chk_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst_ext", bus.ext_addr_cyc, 1);
        do_reset();
        bus.irq = 4'b0001;
        run_instr(0);
        check("midrst_pa", last_data_pa, 1);
        check("midrst_ack", bus.intr_ack, 0);

        clr_ops();
        bus.jmp_valid = 1; bus.jmp_call = 1; bus.jmp_offset = 12'h001;
        for (int i = 1; i <= 17; i++) begin
            run_instr(0);
            if (i == 16) check("ovf_16", bus.stack_ovf, 0);
        end
        check("ovf_17", bus.stack_ovf, 1);

        do_reset();
        run_instr(0);
        run_instr(0);
        bus.ret = 1;
        run_instr(0);
        check("unf_pa", last_data_pa, 0);
        check("unf_flag", bus.stack_unf, 1);

        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 0) do_reset();
            rand_ops(nw);
            run_instr(nw);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/isp8_intr_flow_cntl.md
ISP8_INTR_FLOW_CNTL -- requirements
Module: isp8_intr_flow_cntl

Interface
REQ-001 Parameter PROM_AW, default 12, program address width.
REQ-002 Parameter PGM_STACK_AW, default 4, stack depth is 2**PGM_STACK_AW entries.
REQ-003 Parameter NUM_IRQ, default 4, interrupt channel count (1..8).
REQ-004 Parameter VEC_STRIDE, default 4, words between vectors; vector(i) = i*VEC_STRIDE.
REQ-005 The ports SHALL be:
- clk  in  1  clock, one clock domain.
- rst  in  1  synchronous, active-high reset.
- setc/clrc/setz/clrz/seti/clri  in  1 each  flag set/clear opcodes.
- jmp_valid  in  1  branch or call decoded.
- jmp_call  in  1  qualifies jmp_valid as call.
- jmp_cond  in  3  0 always, 1 Z, 2 NZ, 3 C, 4 NC; 5-7 never.
- jmp_offset  in  PROM_AW  signed PC-relative offset.
- ret, iret  in  1 each  return opcodes.
- ext_cycle  in  1  current opcode needs an external bus cycle.
- ready  in  1  external cycle complete.
- update_c, update_z  in  1 each  ALU flag update.
- cout_alu  in  1; dout_alu  in  8  ALU results.
- irq  in  NUM_IRQ  level-sensitive requests, bit 0 highest priority.
- addr_cyc, ext_addr_cyc, data_cyc  out  1 each  phase strobes.
- prom_addr  out  PROM_AW; prom_enable  out  1.
- carry_flag, zero_flag  out  1 each.
- intr_ack  out  NUM_IRQ  in-service mask.
- stack_ovf, stack_unf  out  1 each  sticky error flags.

Function
REQ-006 Phase FSM SHALL be ADDR -> EXT if ext_cycle else DATA; EXT holds while !ready, -> DATA on ready; DATA -> ADDR; exactly one strobe high each cycle.
REQ-007 prom_enable SHALL equal data_cyc | rst.
REQ-008 Jump taken = jmp_valid & condition per jmp_cond, evaluated on flags at ADDR, registered with jmp_offset at ADDR.
REQ-009 Pending interrupt index SHALL be the lowest set bit of irq & eligible mask, sampled at ADDR while ie_flag=1.
REQ-010 Next address priority in DATA: interrupt take (pending, no taken jump, no ret/iret) -> vector(index); else ret/iret -> stack top; else taken jump -> pc+jmp_offset mod 2**PROM_AW; else pc+1 mod 2**PROM_AW.
REQ-011 prom_addr SHALL be combinational next address; pc SHALL load prom_addr at DATA.
REQ-012 Call taken or interrupt take SHALL push {C,Z,pc+1} and increment stack count at DATA; ret/iret SHALL pop at DATA.
REQ-013 Push at full count SHALL drop the write, set stack_ovf; pop at empty SHALL return address 0, keep count 0, set stack_unf.
REQ-014 Interrupt take SHALL set intr_ack[index]; iret SHALL clear the highest-priority set intr_ack bit and restore C and Z from the popped entry.
REQ-015 Flag update priority: clr over set over iret restore over ALU; zero_flag uses dout_alu registered one cycle; C and Z pushed reflect same-cycle updates.
REQ-016 ie_flag: clri wins over seti when both asserted.

Reset
REQ-017 On rst: addr_cyc=1, ext_addr_cyc=0, data_cyc=0, pc=0, prom_addr=0, flags=0, ie_flag=0, intr_ack=0, stack count 0, stack_ovf=stack_unf=0; mid-operation reset aborts EXT and discards pending irq.

Configuration
REQ-018 With ISP8_NESTED_INTR_EN defined, eligible mask SHALL be bits strictly higher priority than the highest set intr_ack bit; without it eligible SHALL be all bits only when intr_ack==0, else none.

Structure
REQ-019 Package isp8_flow_pkg SHALL hold jmp_cond encodings and phase-state enum.
REQ-020 Stack SHALL be sub-module isp8_pgm_stack (register array, count, full/empty).

Verification
REQ-021 Reset, no opcodes -> prom_addr 1,2,3 on successive DATA phases, phase period 2 clocks.
REQ-022 ext_cycle=1, ready low 3 cycles -> ext_addr_cyc high 4 cycles, then data_cyc.
REQ-023 pc=0x010, call jmp_offset=0x020 -> prom_addr 0x030; later ret -> 0x011.
REQ-024 seti, irq=4'b0110 -> prom_addr 0x004, intr_ack=4'b0010; C=1 before, clrc in ISR, iret -> C=1.
REQ-025 Nested build: in ISR 2, irq[0] -> vector 0x000, intr_ack=4'b0101; non-nested build: ignored.
REQ-026 17 calls with PGM_STACK_AW=4 -> stack_ovf=1; ret at empty -> prom_addr 0, stack_unf=1.
